// File: rtl/alu_pkg.sv
// Shared op-code encoding, FSM state type and op classification for the EX-stage ALU.
package alu_pkg;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_OR    = 4'b0010;
   localparam logic [3:0] ALU_AND   = 4'b0011;
   localparam logic [3:0] ALU_SLTU  = 4'b0100;
   localparam logic [3:0] ALU_SLL   = 4'b0101;
   localparam logic [3:0] ALU_SRL   = 4'b0110;
   localparam logic [3:0] ALU_SGTU  = 4'b0111;
   localparam logic [3:0] ALU_XOR   = 4'b1000;
   localparam logic [3:0] ALU_SRA   = 4'b1001;
   localparam logic [3:0] ALU_SLT   = 4'b1010;
   localparam logic [3:0] ALU_MUL   = 4'b1011;
   localparam logic [3:0] ALU_MULHU = 4'b1100;
   localparam logic [3:0] ALU_DIVU  = 4'b1101;
   localparam logic [3:0] ALU_REMU  = 4'b1110;
   localparam logic [3:0] ALU_ILL   = 4'b1111;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } alu_state_t;

   function automatic logic is_multi_cycle(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unit: shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             abort,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] res
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic               running;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   opnd;
   logic [3:0]         op_r;
   logic               is_div;
   logic               start_div;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     rem_try;
   logic [WIDTH:0]     sub_res;

   assign is_div    = (op_r == ALU_DIVU) || (op_r == ALU_REMU);
   assign start_div = (op == ALU_DIVU) || (op == ALU_REMU);

   // Divide by zero needs no special case: every trial subtract succeeds,
   // so the quotient fills with ones and the remainder shifts in the dividend.
   always_comb begin
      add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      rem_try  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      sub_res  = rem_try - {1'b0, opnd};
      acc_next = {add_sum, acc[WIDTH-1:1]};
      if (is_div) begin
         if (rem_try >= {1'b0, opnd})
            acc_next = {sub_res[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_next = {rem_try[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (abort) begin
         running <= 1'b0;
         cnt     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= CW'(WIDTH);
         op_r    <= op;
         opnd    <= start_div ? b : a;
         acc     <= {{WIDTH{1'b0}}, (start_div ? a : b)};
      end else if (running) begin
         if (cnt != '0) begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
         end else begin
            running <= 1'b0;
         end
      end
   end

   assign done = running && (cnt == '0);

   always_comb begin
      res = acc[2*WIDTH-1:WIDTH];
      if ((op_r == ALU_MUL) || (op_r == ALU_DIVU))
         res = acc[WIDTH-1:0];
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU with valid/ready handshakes, flush, and optional iterative mul/div.
// state | meaning
// IDLE  | accepting ops; single-cycle ops complete here
// BUSY  | iterative mul/div running; input side stalled
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter bit MULDIV_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero_flag,
   output logic             illegal_op
);

   localparam int SW = $clog2(WIDTH);

   alu_state_t       state;
   alu_state_t       state_next;
   logic             accept;
   logic             multi;
   logic             op_illegal;
   logic             load_single;
   logic             md_start;
   logic             md_done;
   logic [WIDTH-1:0] md_res;
   logic [WIDTH-1:0] alu_res;
   logic [SW-1:0]    shamt;

   assign multi      = MULDIV_EN && is_multi_cycle(op);
   assign op_illegal = (op == ALU_ILL) || (!MULDIV_EN && is_multi_cycle(op));

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept && multi) state_next = BUSY;
            BUSY:    if (md_done) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // in_ready deliberately excludes in_valid and flush; flush only gates the accept.
   always_comb begin
      in_ready    = (state == IDLE) && (!out_valid || out_ready);
      accept      = in_valid && in_ready && !flush;
      md_start    = accept && multi;
      load_single = accept && !multi;
   end

   assign shamt = in2[SW-1:0];

   always_comb begin
      alu_res = '0;
      case (op)
         ALU_ADD:  alu_res = in1 + in2;
         ALU_SUB:  alu_res = in1 - in2;
         ALU_OR:   alu_res = in1 | in2;
         ALU_AND:  alu_res = in1 & in2;
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
         ALU_SLL:  alu_res = in1 << shamt;
         ALU_SRL:  alu_res = in1 >> shamt;
         ALU_SGTU: alu_res = {{(WIDTH-1){1'b0}}, (in1 > in2)};
         ALU_XOR:  alu_res = in1 ^ in2;
         ALU_SRA:  alu_res = $unsigned($signed(in1) >>> shamt);
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
         default:  alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         result     <= '0;
         zero_flag  <= 1'b0;
         illegal_op <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load_single) begin
         out_valid  <= 1'b1;
         result     <= alu_res;
         zero_flag  <= (alu_res == '0);
         illegal_op <= op_illegal;
      end else if ((state == BUSY) && md_done) begin
         out_valid  <= 1'b1;
         result     <= md_res;
         zero_flag  <= (md_res == '0);
         illegal_op <= 1'b0;
      end else if (md_start || out_ready) begin
         out_valid <= 1'b0;
      end
   end

   if (MULDIV_EN) begin : g_muldiv
      alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
         .clk   (clk),
         .abort (flush || reset),
         .start (md_start),
         .op    (op),
         .a     (in1),
         .b     (in2),
         .done  (md_done),
         .res   (md_res)
      );
   end else begin : g_no_muldiv
      assign md_done = 1'b0;
      assign md_res  = '0;
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized self-checking bench for alu_pipe (WIDTH=32) against an arithmetic reference model.
module tb_alu_pipe;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = 4'h0;
   logic [31:0] in1 = '0;
   logic [31:0] in2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        zero_flag;
   logic        illegal_op;

   int total = 0;
   int bad   = 0;

   alu_pipe #(.WIDTH(32), .MULDIV_EN(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .in1        (in1),
      .in2        (in2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .zero_flag  (zero_flag),
      .illegal_op (illegal_op)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      longint unsigned p;
      logic [31:0] ones;
      int sh;
      ones = 32'hFFFF_FFFF;
      sh = int'(b % 32);
      p = longint'(a) * longint'(b);
      case (o)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a | b;
         4'd3:    return a & b;
         4'd4:    return (a < b) ? 32'd1 : 32'd0;
         4'd5:    return a << sh;
         4'd6:    return a >> sh;
         4'd7:    return (a > b) ? 32'd1 : 32'd0;
         4'd8:    return a ^ b;
         4'd9:    return (a >> sh) | ((a >= 32'h8000_0000) ? ~(ones >> sh) : 32'd0);
         4'd10:   return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd11:   return p[31:0];
         4'd12:   return p[63:32];
         4'd13:   return (b == 0) ? ones : a / b;
         4'd14:   return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   // Drives one op, scrambles the inputs after accept, waits for the result
   // with out_ready low, then consumes it. lat = rising edges after the accept edge.
   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic zf, output logic ill,
                         output logic ir_held, output logic ir_busy_bad, output int lat);
      int guard;
      @(negedge clk);
      out_ready = 1'b0;
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b1; op = o; in1 = a; in2 = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0; op = 4'($urandom); in1 = $urandom; in2 = $urandom;
      lat = 0;
      ir_busy_bad = 1'b0;
      while (1) begin
         @(negedge clk);
         if (out_valid || lat > 200) break;
         if (in_ready) ir_busy_bad = 1'b1;
         @(posedge clk);
         lat++;
      end
      r = result; zf = zero_flag; ill = illegal_op; ir_held = in_ready;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero_flag !== 1'b0 || illegal_op !== 1'b0) begin
         bad++;
         $display("FAIL reset got ir=%b ov=%b res=%h zf=%b ill=%b want ir=1 ov=0 res=0 zf=0 ill=0",
                  in_ready, out_valid, result, zero_flag, illegal_op);
      end
      reset = 1'b0;
   endtask

   task automatic test_directed();
      logic [3:0]  dop[4] = '{ALU_ADD, ALU_SRA, ALU_SLT, ALU_SLTU};
      logic [31:0] da[4]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] db[4]  = '{32'd1, 32'h24, 32'd1, 32'd1};
      logic [31:0] dexp[4] = '{32'd0, 32'hF800_0000, 32'd1, 32'd0};
      logic [31:0] r;
      logic zf, ill, irh, irb;
      int lat;
      for (int i = 0; i < 4; i++) begin
         run_op(dop[i], da[i], db[i], r, zf, ill, irh, irb, lat);
         total++;
         if (r !== dexp[i] || zf !== (dexp[i] == 0) || ill !== 1'b0 || lat != 0 || irh !== 1'b0) begin
            bad++;
            $display("FAIL directed%0d got res=%h zf=%b ill=%b lat=%0d ir=%b want res=%h zf=%b ill=0 lat=0 ir=0",
                     i, r, zf, ill, lat, irh, dexp[i], (dexp[i] == 0));
         end
      end
   endtask

   task automatic test_random_single();
      logic [31:0] a, b, r, e;
      logic [3:0] o;
      logic zf, ill, irh, irb;
      int lat;
      for (int i = 0; i < 40; i++) begin
         o = 4'($urandom_range(0, 10));
         a = $urandom;
         b = (i % 4 == 0) ? a : $urandom;
         e = model(o, a, b);
         run_op(o, a, b, r, zf, ill, irh, irb, lat);
         total++;
         if (r !== e || zf !== (e == 0) || ill !== 1'b0 || lat != 0) begin
            bad++;
            $display("FAIL single op=%0d a=%h b=%h got res=%h zf=%b ill=%b lat=%0d want res=%h lat=0",
                     o, a, b, r, zf, ill, lat, e);
         end
      end
   endtask

   task automatic test_muldiv();
      logic [3:0]  mop[6] = '{ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU, ALU_DIVU, ALU_REMU};
      logic [31:0] ma[6]  = '{32'h10000, 32'h10000, 32'd100, 32'd100, 32'd5, 32'd5};
      logic [31:0] mb[6]  = '{32'h10000, 32'h10000, 32'd7, 32'd7, 32'd0, 32'd0};
      logic [31:0] mexp[6] = '{32'd0, 32'd1, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
      logic [31:0] a, b, r, e;
      logic [3:0] o;
      logic zf, ill, irh, irb;
      int lat;
      for (int i = 0; i < 6; i++) begin
         run_op(mop[i], ma[i], mb[i], r, zf, ill, irh, irb, lat);
         total++;
         if (r !== mexp[i] || lat != 33 || irb !== 1'b0 || ill !== 1'b0 || zf !== (mexp[i] == 0)) begin
            bad++;
            $display("FAIL muldiv%0d got res=%h lat=%0d ir_busy=%b ill=%b zf=%b want res=%h lat=33 ir_busy=0",
                     i, r, lat, irb, ill, zf, mexp[i]);
         end
      end
      for (int i = 0; i < 12; i++) begin
         o = 4'($urandom_range(11, 14));
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
         e = model(o, a, b);
         run_op(o, a, b, r, zf, ill, irh, irb, lat);
         total++;
         if (r !== e || lat != 33 || irb !== 1'b0) begin
            bad++;
            $display("FAIL muldiv_rand op=%0d a=%h b=%h got res=%h lat=%0d want res=%h lat=33",
                     o, a, b, r, lat, e);
         end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] r;
      logic zf, ill, irh, irb;
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_op(ALU_ILL, $urandom, $urandom, r, zf, ill, irh, irb, lat);
         total++;
         if (r !== 32'd0 || zf !== 1'b1 || ill !== 1'b1 || lat != 0) begin
            bad++;
            $display("FAIL illegal got res=%h zf=%b ill=%b lat=%0d want res=0 zf=1 ill=1 lat=0", r, zf, ill, lat);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] q[$];
      logic [3:0]  bo[10];
      logic [31:0] ba[10], bb[10];
      logic [31:0] held;
      logic stalled;
      int sent, got;
      for (int i = 0; i < 10; i++) begin
         bo[i] = 4'($urandom_range(0, 10));
         ba[i] = $urandom;
         bb[i] = $urandom;
      end
      sent = 0; got = 0; stalled = 1'b0; held = '0;
      for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
         @(negedge clk);
         out_ready = (cyc % 2 == 0);
         if (sent < 10) begin
            in_valid = 1'b1; op = bo[sent]; in1 = ba[sent]; in2 = bb[sent];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (stalled) begin
            total++;
            if (out_valid !== 1'b1 || result !== held) begin
               bad++;
               $display("FAIL b2b_stall got ov=%b res=%h want ov=1 res=%h", out_valid, result, held);
            end
         end
         if (out_valid && out_ready) begin
            total++;
            if (q.size() == 0 || result !== q[0]) begin
               bad++;
               $display("FAIL b2b_result got res=%h want res=%h (queued=%0d)", result,
                        (q.size() != 0) ? q[0] : 32'd0, q.size());
            end
            if (q.size() != 0) void'(q.pop_front());
            got++;
         end
         stalled = out_valid && !out_ready;
         held = result;
         if (in_valid && in_ready) begin
            q.push_back(model(bo[sent], ba[sent], bb[sent]));
            sent++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      total++;
      if (got != 10 || q.size() != 0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_count got consumed=%0d left=%0d ov=%b want consumed=10 left=0 ov=0",
                  got, q.size(), out_valid);
      end
   endtask

   task automatic test_flush();
      logic [31:0] r;
      logic zf, ill, irh, irb;
      int lat, spurious;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1; op = ALU_DIVU; in1 = 32'd1000; in2 = 32'd3;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      in_valid = 1'b1; op = ALU_ADD; in1 = 32'd5; in2 = 32'd6;
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL flush_state got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
      end
      spurious = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) spurious++;
      end
      total++;
      if (spurious != 0) begin
         bad++;
         $display("FAIL flush_quiet got valid_cycles=%0d want 0", spurious);
      end
      run_op(ALU_ADD, 32'd7, 32'd8, r, zf, ill, irh, irb, lat);
      total++;
      if (r !== 32'd15 || lat != 0 || ill !== 1'b0) begin
         bad++;
         $display("FAIL flush_after_add got res=%h lat=%0d ill=%b want res=0000000f lat=0 ill=0", r, lat, ill);
      end
   endtask

   task automatic test_reset_mid();
      int spurious;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; op = ALU_MUL; in1 = 32'd12345; in2 = 32'd678;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0 || illegal_op !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid got ov=%b ir=%b res=%h ill=%b want ov=0 ir=1 res=0 ill=0",
                  out_valid, in_ready, result, illegal_op);
      end
      spurious = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) spurious++;
      end
      total++;
      if (spurious != 0) begin
         bad++;
         $display("FAIL reset_mid_quiet got valid_cycles=%0d want 0", spurious);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random_single();
      test_muldiv();
      test_illegal();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
